// File: rtl/crc_lfsr_serial_if.sv
// Word-in / CRC-out handshake bundle for crc_lfsr_serial.
// master = word source and result consumer; slave = CRC engine.
interface crc_lfsr_serial_if #(
  parameter int unsigned CRC_W  = 8,
  parameter int unsigned DATA_W = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_first;
  logic              in_last;
  logic [CRC_W-1:0]  crc_out;
  logic              crc_valid;
  logic              crc_ready;

  modport master (
    output in_valid, in_data, in_first, in_last, crc_ready,
    input  in_ready, crc_out, crc_valid
  );

  modport slave (
    input  in_valid, in_data, in_first, in_last, crc_ready,
    output in_ready, crc_out, crc_valid
  );
endinterface

// File: rtl/crc_lfsr_serial.sv
// Bit-serial XOR-feedback CRC engine: folds each DATA_W-bit word MSB first,
// one bit per clock, and presents the frame CRC on a held valid/ready output.
module crc_lfsr_serial #(
  parameter int unsigned        CRC_W   = 8,
  parameter logic [CRC_W-1:0]   POLY    = CRC_W'(8'h07),
  parameter logic [CRC_W-1:0]   INIT    = '0,
  parameter logic [CRC_W-1:0]   XOR_OUT = '0,
  parameter int unsigned        DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  crc_lfsr_serial_if.slave  bus
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t              state_q, state_d;
  logic [CRC_W-1:0]    crc_q, crc_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                last_q, last_d;
  logic                in_ready_q, in_ready_d;
  logic                crc_valid_q, crc_valid_d;
  logic [CRC_W-1:0]    crc_out_q, crc_out_d;
  logic                fb;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      crc_q       <= INIT;
      shreg_q     <= '0;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      crc_valid_q <= 1'b0;
      crc_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      in_ready_q  <= in_ready_d;
      crc_valid_q <= crc_valid_d;
      crc_out_q   <= crc_out_d;
    end
  end

  assign fb = crc_q[CRC_W-1] ^ shreg_q[DATA_W-1];

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          shreg_d = bus.in_data;
          last_d  = bus.in_last;
          cnt_d   = CNT_W'(DATA_W - 1);
          state_d = SHIFT;
          if (bus.in_first) crc_d = INIT;
        end
      end
      SHIFT: begin
        crc_d   = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        shreg_d = shreg_q << 1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = last_q ? DONE : IDLE;
        end
      end
      DONE: begin
        if (bus.crc_ready) begin
          crc_d   = INIT;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values for the upcoming cycle, registered above
  always_comb begin
    in_ready_d  = (state_d == IDLE);
    crc_valid_d = (state_d == DONE);
    crc_out_d   = crc_valid_d ? (crc_d ^ XOR_OUT) : '0;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.crc_valid = crc_valid_q;
  assign bus.crc_out   = crc_out_q;

endmodule

// File: tb/tb_crc_lfsr_serial.sv
// Scoreboard bench for crc_lfsr_serial: a CRC-8 instance and a CRC-16/CCITT-FALSE instance.
module tb_crc_lfsr_serial;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  crc_lfsr_serial_if #(.CRC_W(8),  .DATA_W(8)) bus8 ();
  crc_lfsr_serial_if #(.CRC_W(16), .DATA_W(8)) bus16 ();

  crc_lfsr_serial #(.CRC_W(8), .POLY(8'h07), .INIT(8'h00), .XOR_OUT(8'h00), .DATA_W(8))
    u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  crc_lfsr_serial #(.CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .XOR_OUT(16'h0000), .DATA_W(8))
    u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [31:0] q8[$];
  logic [31:0] q16[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference CRC, conventional MSB-first byte-at-a-time form
  function automatic logic [31:0] crc_ref(input int w, input logic [31:0] poly,
                                          input logic [31:0] init, input logic [31:0] xo,
                                          input logic [7:0] d[$]);
    logic [31:0] mask, c;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    c = init & mask;
    foreach (d[i]) begin
      c = c ^ (32'(d[i]) << (w - 8));
      for (int b = 0; b < 8; b++)
        c = c[w-1] ? (((c << 1) ^ poly) & mask) : ((c << 1) & mask);
    end
    return (c ^ xo) & mask;
  endfunction

  // Result monitors: a handshake at the next edge consumes one expected value
  always @(negedge clk) begin
    if (rst_n && bus8.crc_valid && bus8.crc_ready) begin
      if (q8.size() == 0) check("crc8_unexpected", 32'd1, 32'd0);
      else                check("crc8_out", 32'(bus8.crc_out), q8.pop_front());
    end
    if (rst_n && bus16.crc_valid && bus16.crc_ready) begin
      if (q16.size() == 0) check("crc16_unexpected", 32'd1, 32'd0);
      else                 check("crc16_out", 32'(bus16.crc_out), q16.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send8(input logic [7:0] d, input logic first, input logic last, output int acc);
    int k;
    bus8.in_valid = 1'b1; bus8.in_data = d; bus8.in_first = first; bus8.in_last = last;
    for (k = 0; k < 100 && !bus8.in_ready; k++) tick();
    if (!bus8.in_ready) check("send8_timeout", 32'd0, 32'd1);
    tick();
    acc = cyc;
  endtask

  task automatic send16(input logic [7:0] d, input logic first, input logic last);
    int k;
    bus16.in_valid = 1'b1; bus16.in_data = d; bus16.in_first = first; bus16.in_last = last;
    for (k = 0; k < 100 && !bus16.in_ready; k++) tick();
    if (!bus16.in_ready) check("send16_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic frame8(input logic [7:0] d[$], input logic [15:0] fmask, input logic [31:0] exp);
    int t;
    q8.push_back(exp);
    foreach (d[i]) send8(d[i], fmask[i], i == d.size() - 1, t);
    bus8.in_valid = 1'b0;
  endtask

  task automatic frame16(input logic [7:0] d[$], input logic [15:0] fmask, input logic [31:0] exp);
    q16.push_back(exp);
    foreach (d[i]) send16(d[i], fmask[i], i == d.size() - 1);
    bus16.in_valid = 1'b0;
  endtask

  task automatic wait_valid8(output int lat);
    lat = 0;
    while (!bus8.crc_valid && lat < 200) begin tick(); lat++; end
    if (!bus8.crc_valid) check("wait_valid8_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input string tag);
    int k;
    for (k = 0; k < 500 && (q8.size() != 0 || q16.size() != 0); k++) tick();
    if (q8.size() != 0 || q16.size() != 0) check({tag, "_drain_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d[$];
    logic [31:0] hold, e;
    int lat, t, tprev, len;
    logic saw;

    bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.in_first = 1'b0; bus8.in_last = 1'b0;
    bus8.crc_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.in_data = '0; bus16.in_first = 1'b0; bus16.in_last = 1'b0;
    bus16.crc_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_in_ready", 32'(bus8.in_ready), 32'd1);
    check("rst_crc_valid", 32'(bus8.crc_valid), 32'd0);
    check("rst_crc_out", 32'(bus8.crc_out), 32'd0);
    check("rst16_in_ready", 32'(bus16.in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Single word 0x01: latency and in_ready return
    q8.push_back(32'h07);
    send8(8'h01, 1'b1, 1'b1, t);
    bus8.in_valid = 1'b0;
    wait_valid8(lat);
    check("latency", 32'(lat), 32'd8);
    tick();
    check("ready_after_done", 32'(bus8.in_ready), 32'd1);
    check("valid_after_done", 32'(bus8.crc_valid), 32'd0);

    d = '{8'h80}; frame8(d, 16'h1, 32'h89);
    drain("w80");
    d = '{8'h00}; frame8(d, 16'h1, 32'h00);
    drain("w00");

    // "123456789" with in_valid held: one acceptance per 9 cycles
    q8.push_back(32'hF4);
    tprev = 0;
    for (int i = 0; i < 9; i++) begin
      send8(8'h31 + 8'(i), i == 0, i == 8, t);
      if (i > 0) check("word_period", 32'(t - tprev), 32'd9);
      tprev = t;
    end
    bus8.in_valid = 1'b0;
    drain("check123");

    // Backpressure on the result
    bus8.crc_ready = 1'b0;
    d = '{8'h5A};
    frame8(d, 16'h1, crc_ref(8, 32'h07, 32'h00, 32'h00, d));
    wait_valid8(lat);
    hold = 32'(bus8.crc_out);
    bus8.in_valid = 1'b1; bus8.in_data = 8'hFF; bus8.in_first = 1'b1; bus8.in_last = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_valid", 32'(bus8.crc_valid), 32'd1);
      check("bp_stable", 32'(bus8.crc_out), hold);
      check("bp_in_ready", 32'(bus8.in_ready), 32'd0);
    end
    bus8.in_valid = 1'b0;
    bus8.crc_ready = 1'b1;
    drain("bp");
    d = '{8'h01}; frame8(d, 16'h0, 32'h07);
    drain("after_bp");

    // Reset during SHIFT of word 3
    send8(8'h11, 1'b1, 1'b0, t);
    send8(8'h22, 1'b0, 1'b0, t);
    send8(8'h33, 1'b0, 1'b0, t);
    bus8.in_valid = 1'b0;
    repeat (3) tick();
    #1 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(bus8.in_ready), 32'd1);
    check("midrst_crc_valid", 32'(bus8.crc_valid), 32'd0);
    check("midrst_crc_out", 32'(bus8.crc_out), 32'd0);
    tick();
    rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin tick(); saw = saw | bus8.crc_valid; end
    check("midrst_no_valid", 32'(saw), 32'd0);
    d = '{8'h01}; frame8(d, 16'h1, 32'h07);
    drain("after_rst");

    // Random multi-word frames against the reference
    for (int f = 0; f < 4; f++) begin
      len = $urandom_range(1, 5);
      d = {};
      for (int i = 0; i < len; i++) d.push_back(8'($urandom_range(0, 255)));
      e = crc_ref(8, 32'h07, 32'h00, 32'h00, d);
      frame8(d, 16'h1, e);
    end
    drain("rand8");

    // CRC-16/CCITT-FALSE
    d = {};
    for (int i = 0; i < 9; i++) d.push_back(8'h31 + 8'(i));
    frame16(d, 16'h1, 32'h29B1);
    drain("ccitt");
    d = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48};
    begin
      logic [7:0] tail[$];
      tail = '{8'h45, 8'h46, 8'h47, 8'h48};
      e = crc_ref(16, 32'h1021, 32'hFFFF, 32'h0000, tail);
    end
    frame16(d, 16'h11, e);
    drain("restart16");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
